// File: rtl/display_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// display_mem_arbiter_if
// Read bus between the display memory arbiter and the single-port sprite ROM.
//
//   rom_en    arbiter -> ROM   read enable, one word per cycle
//   rom_addr  arbiter -> ROM   read address
//   rom_data  ROM -> arbiter   read data, ROM_LAT cycles after rom_en
//
// Modports: master = arbiter side, slave = ROM side.
// ----------------------------------------------------------------------------
interface display_mem_arbiter_if #(
    parameter int AW = 17,
    parameter int DW = 12
);
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    modport master (output rom_en, output rom_addr, input  rom_data);
    modport slave  (input  rom_en, input  rom_addr, output rom_data);
endinterface

// File: rtl/display_mem_arbiter.sv
// ----------------------------------------------------------------------------
// display_mem_arbiter
// Shares one single-port sprite ROM between the display layers
// (0 = mouse, 1 = card, 2 = button). On every pix_en it snapshots the
// layers' addresses, reads them back-to-back in ascending index order and
// publishes all returned pixels together at the following pix_en.
//
// Ports:
//   clk         system clock (100 MHz)
//   rst         asynchronous, active-low reset
//   pix_en      one-cycle strobe per pixel period
//   req_valid   requester i needs a word for the coming pixel
//   req_addr    requester addresses, slice [i*AW +: AW]
//   rom         ROM read bus (display_mem_arbiter_if.master)
//   pix_valid   published word i is valid
//   pix_data    published words, slice [i*DW +: DW]
//   pix_strobe  one-cycle pulse when pix_valid/pix_data update
//   busy        a snapshot is still being served
//   overrun     one-cycle pulse: pix_en arrived while busy
//   overrun_cnt saturating overrun count (only with DISP_ARB_OVERRUN_CNT_EN)
//
// Optional feature macro: DISP_ARB_OVERRUN_CNT_EN
// ----------------------------------------------------------------------------
module display_mem_arbiter #(
    parameter int NREQ    = 3,
    parameter int AW      = 17,
    parameter int DW      = 12,
    parameter int ROM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pix_en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    display_mem_arbiter_if.master rom,
    output logic [NREQ-1:0]      pix_valid,
    output logic [NREQ*DW-1:0]   pix_data,
    output logic                 pix_strobe,
    output logic                 busy,
    output logic                 overrun
`ifdef DISP_ARB_OVERRUN_CNT_EN
    ,
    output logic [15:0]          overrun_cnt
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     pend_q, pend_d;      // snapshot indices not yet read
    logic [NREQ*AW-1:0]  sh_addr_q;           // snapshot addresses
    logic [NREQ-1:0]     res_valid_q, res_valid_d;
    logic [NREQ*DW-1:0]  res_data_q, res_data_d;
    logic [ROM_LAT-1:0]  tag_v_q;             // tag shift register, aligned to rom_data
    logic [IW-1:0]       tag_idx_q [ROM_LAT];
    logic [AW-1:0]       rom_addr_q;

    logic                issue;
    logic [IW-1:0]       issue_idx;
    logic [AW-1:0]       issue_addr;
    logic [NREQ-1:0]     issue_mask;
    logic                ret;
    logic                older_inflight;
    logic                last_ret;
    logic                over;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a variable unassigned and infer a latch.
    always_comb begin
        issue_idx  = '0;
        issue_addr = '0;
        issue_mask = '0;
        // Descending scan so the lowest pending index wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                issue_idx     = IW'(i);
                issue_addr    = sh_addr_q[i*AW +: AW];
                issue_mask    = '0;
                issue_mask[i] = 1'b1;
            end
        end

        issue        = (state_q == ISSUE);
        rom.rom_en   = issue;
        rom.rom_addr = issue ? issue_addr : rom_addr_q;

        ret            = tag_v_q[ROM_LAT-1];
        older_inflight = 1'b0;
        for (int i = 0; i < ROM_LAT - 1; i++) begin
            older_inflight = older_inflight | tag_v_q[i];
        end
        // A pixel period that ends exactly as the final word returns is on time.
        last_ret = (state_q == DRAIN) && ret && !older_inflight;
        over     = pix_en && (state_q != IDLE) && !last_ret;
        busy     = (state_q != IDLE);

        // Returning word is merged here so a same-cycle pix_en publishes it.
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        for (int i = 0; i < NREQ; i++) begin
            if (ret && (tag_idx_q[ROM_LAT-1] == IW'(i))) begin
                res_valid_d[i]          = 1'b1;
                res_data_d[i*DW +: DW]  = rom.rom_data;
            end
        end

        state_d = state_q;
        pend_d  = pend_q;
        if (issue) begin
            pend_d = pend_q & ~issue_mask;
        end
        case (state_q)
            ISSUE:   if (pend_d == '0) state_d = DRAIN;
            DRAIN:   if (last_ret)     state_d = IDLE;
            default: state_d = state_q;
        endcase
        // A new snapshot overrides whatever was in progress.
        if (pix_en) begin
            pend_d  = req_valid;
            state_d = (req_valid != '0) ? ISSUE : IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            sh_addr_q   <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            tag_v_q     <= '0;
            for (int i = 0; i < ROM_LAT; i++) tag_idx_q[i] <= '0;
            rom_addr_q  <= '0;
            pix_valid   <= '0;
            pix_data    <= '0;
            pix_strobe  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pix_strobe <= pix_en;
            overrun    <= over;
            if (issue) rom_addr_q <= issue_addr;

            // pix_en discards all in-flight tags; their returns are never written.
            if (pix_en) begin
                tag_v_q <= '0;
            end else begin
                for (int i = ROM_LAT - 1; i > 0; i--) begin
                    tag_v_q[i]   <= tag_v_q[i-1];
                    tag_idx_q[i] <= tag_idx_q[i-1];
                end
                tag_v_q[0]   <= issue;
                tag_idx_q[0] <= issue_idx;
            end

            res_data_q <= res_data_d;
            if (pix_en) begin
                pix_valid   <= res_valid_d;
                pix_data    <= res_data_d;
                res_valid_q <= '0;
                sh_addr_q   <= req_addr;
            end else begin
                res_valid_q <= res_valid_d;
            end
        end
    end

`ifdef DISP_ARB_OVERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_cnt <= '0;
        end else if (over && (overrun_cnt != 16'hFFFF)) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_display_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_display_mem_arbiter
// Drives two arbiters (ROM_LAT = 1 and ROM_LAT = 2) with the same stimulus:
// directed pixel periods first, then randomized periods and addresses, and a
// reset in the middle of a read burst. Each arbiter is compared every cycle
// against a schedule model: after a snapshot with k pending requests, the
// j-th pending read is issued j cycles later and its word lands at edge
// j+1+ROM_LAT; a word is published only if it landed by the next pix_en.
// ----------------------------------------------------------------------------
module tb_display_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 17;
    localparam int DW   = 12;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                pix_en = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;

    logic [NREQ-1:0]     pv [2];
    logic [NREQ*DW-1:0]  pd [2];
    logic                ps [2];
    logic                bz [2];
    logic                ov [2];
`ifdef DISP_ARB_OVERRUN_CNT_EN
    logic [15:0]         oc [2];
`endif

    always #5 clk = ~clk;

    display_mem_arbiter_if #(.AW(AW), .DW(DW)) rom_if0 ();
    display_mem_arbiter_if #(.AW(AW), .DW(DW)) rom_if1 ();

    display_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(1)) u_dut_lat1 (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .rom        (rom_if0.master),
        .pix_valid  (pv[0]),
        .pix_data   (pd[0]),
        .pix_strobe (ps[0]),
        .busy       (bz[0]),
        .overrun    (ov[0])
`ifdef DISP_ARB_OVERRUN_CNT_EN
        ,
        .overrun_cnt(oc[0])
`endif
    );

    display_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(2)) u_dut_lat2 (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .rom        (rom_if1.master),
        .pix_valid  (pv[1]),
        .pix_data   (pd[1]),
        .pix_strobe (ps[1]),
        .busy       (bz[1]),
        .overrun    (ov[1])
`ifdef DISP_ARB_OVERRUN_CNT_EN
        ,
        .overrun_cnt(oc[1])
`endif
    );

    // ROM contents: a word that depends on every address bit.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[11:0] ^ {a[16:12], 7'h00};
    endfunction

    // ROM models: valid word after ROM_LAT edges, junk on non-read cycles.
    logic [DW-1:0] junk;
    logic          r0_v1;
    logic [AW-1:0] r0_a1;
    logic          r1_v1, r1_v2;
    logic [AW-1:0] r1_a1, r1_a2;

    always @(posedge clk) begin
        junk  <= DW'($urandom);
        r0_v1 <= rom_if0.rom_en;
        r0_a1 <= rom_if0.rom_addr;
        r1_v1 <= rom_if1.rom_en;
        r1_a1 <= rom_if1.rom_addr;
        r1_v2 <= r1_v1;
        r1_a2 <= r1_a1;
    end

    assign rom_if0.rom_data = r0_v1 ? rom_word(r0_a1) : junk;
    assign rom_if1.rom_data = r1_v2 ? rom_word(r1_a2) : junk;

    // ---------------- reference model ----------------
    int            m      [2];       // edges since the last snapshot
    int            k      [2];       // pending requests in that snapshot
    int            l_idx  [2][NREQ];
    logic [AW-1:0] l_addr [2][NREQ];
    logic [NREQ-1:0] e_pv [2];
    logic [DW-1:0] e_pd   [2][NREQ];
    logic [AW-1:0] e_addr [2];
    bit            e_en   [2];
    bit            e_busy [2];
    bit            e_ov   [2];
    int            e_cnt  [2];
    bit            e_ps;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        e_ps = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m[d] = 0; k[d] = 0;
            e_pv[d] = '0; e_addr[d] = '0;
            e_en[d] = 1'b0; e_busy[d] = 1'b0; e_ov[d] = 1'b0;
            e_cnt[d] = 0;
        end
    endtask

    // Called once per rising edge with the inputs that edge sampled.
    task automatic model_step();
        int lat;
        e_ps = pix_en;
        for (int d = 0; d < 2; d++) begin
            lat = d + 1;
            if (m[d] < 1000) m[d]++;
            e_ov[d] = 1'b0;
            if (pix_en) begin
                e_pv[d] = '0;
                for (int j = 0; j < k[d]; j++) begin
                    if (j + 1 + lat <= m[d]) begin
                        e_pv[d][l_idx[d][j]] = 1'b1;
                        e_pd[d][l_idx[d][j]] = rom_word(l_addr[d][j]);
                    end
                end
                e_ov[d] = (k[d] > 0) && (k[d] + lat > m[d]);
                if (e_ov[d] && e_cnt[d] < 65535) e_cnt[d]++;
                k[d] = 0;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i]) begin
                        l_idx[d][k[d]]  = i;
                        l_addr[d][k[d]] = req_addr[i*AW +: AW];
                        k[d]++;
                    end
                end
                m[d] = 0;
            end
            e_en[d]   = (m[d] < k[d]);
            if (e_en[d]) e_addr[d] = l_addr[d][m[d]];
            e_busy[d] = (k[d] > 0) && (m[d] < k[d] + lat);
        end
    endtask

    task automatic check_outputs();
        logic          got_en;
        logic [AW-1:0] got_addr;
        for (int d = 0; d < 2; d++) begin
            got_en   = (d == 0) ? rom_if0.rom_en   : rom_if1.rom_en;
            got_addr = (d == 0) ? rom_if0.rom_addr : rom_if1.rom_addr;
            check($sformatf("lat%0d rom_en", d + 1),     32'(got_en),   32'(e_en[d]));
            check($sformatf("lat%0d rom_addr", d + 1),   32'(got_addr), 32'(e_addr[d]));
            check($sformatf("lat%0d busy", d + 1),       32'(bz[d]),    32'(e_busy[d]));
            check($sformatf("lat%0d pix_strobe", d + 1), 32'(ps[d]),    32'(e_ps));
            check($sformatf("lat%0d overrun", d + 1),    32'(ov[d]),    32'(e_ov[d]));
            check($sformatf("lat%0d pix_valid", d + 1),  32'(pv[d]),    32'(e_pv[d]));
            for (int i = 0; i < NREQ; i++) begin
                if (e_pv[d][i]) begin
                    check($sformatf("lat%0d pix_data[%0d]", d + 1, i),
                          32'(pd[d][i*DW +: DW]), 32'(e_pd[d][i]));
                end
            end
`ifdef DISP_ARB_OVERRUN_CNT_EN
            check($sformatf("lat%0d overrun_cnt", d + 1), 32'(oc[d]), 32'(e_cnt[d]));
`endif
        end
    endtask

    // One clock: model follows the edge, outputs are checked 1 ns later.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_step();
        else     model_reset();
        #1;
        check_outputs();
    endtask

    // One pixel period of len cycles; pix_en in the first cycle.
    task automatic period(input int len, input logic [NREQ-1:0] rv, input bit rnd);
        for (int c = 0; c < len; c++) begin
            pix_en    = (c == 0);
            req_valid = (c == 0 || !rnd) ? rv : NREQ'($urandom);
            if (rnd) req_addr = {AW'($urandom), AW'($urandom), AW'($urandom)};
            cycle();
        end
    endtask

    initial begin
        int len;
        model_reset();

        // Reset held, then released with no pix_en: everything stays at zero.
        for (int c = 0; c < 3; c++) cycle();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) cycle();

        // All three layers, then a gap, then no requests at all.
        req_addr = {17'h00030, 17'h00020, 17'h00010};
        period(4, 3'b111, 1'b0);
        period(4, 3'b111, 1'b0);
        period(4, 3'b101, 1'b0);
        period(4, 3'b000, 1'b0);
        period(4, 3'b000, 1'b0);

        // Randomized periods, mostly the nominal 4 cycles.
        for (int p = 0; p < 250; p++) begin
            len = ($urandom_range(0, 9) < 5) ? 4 : int'($urandom_range(1, 8));
            period(len, NREQ'($urandom), 1'b1);
        end

        // Reset in the middle of a burst, after the first read went out.
        req_addr = {17'h1F0A3, 17'h0B5C4, 17'h12345};
        period(4, 3'b111, 1'b0);
        period(2, 3'b111, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        cycle();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        // Nothing from the aborted burst may show up in the next publish.
        period(4, 3'b000, 1'b0);
        period(4, 3'b110, 1'b0);
        period(6, 3'b000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
